// File: rtl/branch_target_predictor.sv
// Branch target buffer with per-entry saturating direction counters; zero-latency lookup.
// Optional statistics counters are enabled with `define BTP_STATS_EN.
module branch_target_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned CNT_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  input  logic              clear
`ifdef BTP_STATS_EN
  ,
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
  localparam int unsigned TGT_W = ADDR_W - 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));

  logic [ENTRIES-1:0] r_valid;
  logic [CNT_W-1:0]   r_cnt [ENTRIES];
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [TGT_W-1:0]   r_tgt [ENTRIES];

  logic [IDX_W-1:0]   w_fidx;
  logic [TAG_W-1:0]   w_ftag;
  logic [IDX_W-1:0]   w_uidx;
  logic [TAG_W-1:0]   w_utag;
  logic               w_uhit;
  logic               w_data_wr;
  logic [CNT_W-1:0]   w_cnt_nxt;

  assign w_fidx = fetch_pc[IDX_W+1:2];
  assign w_ftag = fetch_pc[ADDR_W-1:IDX_W+2];
  assign w_uidx = upd_pc[IDX_W+1:2];
  assign w_utag = upd_pc[ADDR_W-1:IDX_W+2];

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign hit         = r_valid[w_fidx] && (r_tag[w_fidx] == w_ftag);
  assign pred_taken  = hit && r_cnt[w_fidx][CNT_W-1];
  assign pred_target = pred_taken ? {r_tgt[w_fidx], 2'b00} : '0;

  assign w_uhit    = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_data_wr = !clear && upd_valid && upd_taken;

  always_comb begin
    w_cnt_nxt = r_cnt[w_uidx];
    if (upd_taken) begin
      if (r_cnt[w_uidx] != CNT_MAX) w_cnt_nxt = r_cnt[w_uidx] + CNT_W'(1);
    end else begin
      if (r_cnt[w_uidx] != '0) w_cnt_nxt = r_cnt[w_uidx] - CNT_W'(1);
    end
  end

  // Valid bits and counters; clear wins over a same-cycle update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= '0;
    end else if (clear) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_cnt[i] <= '0;
    end else if (upd_valid) begin
      if (w_uhit) begin
        r_cnt[w_uidx] <= w_cnt_nxt;
      end else if (upd_taken) begin
        r_valid[w_uidx] <= 1'b1;
        r_cnt[w_uidx]   <= CNT_WEAK;
      end
    end
  end

  // Tag/target storage needs no reset: it is qualified by r_valid.
  always_ff @(posedge clk) begin
    if (w_data_wr) begin
      r_tag[w_uidx] <= w_utag;
      r_tgt[w_uidx] <= upd_target[ADDR_W-1:2];
    end
  end

  logic w_unused_bits;
  assign w_unused_bits = ^{fetch_pc[1:0], upd_pc[1:0], upd_target[1:0]};

`ifdef BTP_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (fetch_valid)                 stat_lookups     <= stat_lookups + 32'd1;
      if (fetch_valid && hit)          stat_hits        <= stat_hits + 32'd1;
      if (upd_valid && upd_mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`else
  logic w_unused_stats;
  assign w_unused_stats = fetch_valid ^ upd_mispredict;
`endif

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters for the pipelined MIPS core.
- The fetch stage looks it up with the current PC and gets a predicted next PC in the same cycle. The EX stage updates it once a branch or jump resolves.
- Replaces always-not-taken fetch. The core flushes only on misprediction, instead of flushing IF/ID on every taken branch.

Parameters:
- ENTRIES, 16, number of table entries; power of two, 2..256. IDX_W = log2(ENTRIES).
- ADDR_W, 32, PC width. Bits [1:0] are ignored; bit ADDR_W-1 is the kernel/supervisor bit.
- CNT_W, 2, direction counter width; 1..4.

Ports:
- clk  input  1  core pipeline clock
- reset  input  1  asynchronous, active-low
- fetch_valid  input  1  a lookup is performed this cycle; used only for statistics
- fetch_pc  input  ADDR_W  PC being fetched
- hit  output  1  valid entry with matching tag for fetch_pc
- pred_taken  output  1  hit and counter MSB set
- pred_target  output  ADDR_W  predicted target; 0 when pred_taken=0
- upd_valid  input  1  resolved control-transfer instruction this cycle
- upd_pc  input  ADDR_W  PC of the resolved instruction
- upd_taken  input  1  actual direction
- upd_target  input  ADDR_W  actual target; meaningful when upd_taken=1
- upd_mispredict  input  1  fetch-time prediction was wrong; used only for statistics
- clear  input  1  synchronous invalidate of all entries

Behaviour:
- Index and tag:
  - idx = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2].
  - The tag includes the kernel bit, so 0x00000040 and 0x80000040 never alias as hits.
- Entry contents: valid, tag, target[ADDR_W-1:2], counter[CNT_W-1:0]. Target low bits read back as 00.
- Lookup:
  - Purely combinational from registered state; zero latency.
  - hit = valid[idx] && tag match.
  - pred_taken = hit && counter[CNT_W-1].
- Update (posedge clk, upd_valid=1):
  - Tag hit:
    - upd_taken=1 → counter increments, saturating at all-ones; target overwritten.
    - upd_taken=0 → counter decrements, saturating at 0; target kept.
  - Miss with upd_taken=1 → allocate or replace: valid=1, tag and target written, counter = weakly taken (MSB=1, others 0; for CNT_W=1 this is 1).
  - Miss with upd_taken=0 → no change; no allocation on not-taken.
- Same-cycle lookup and update, any index: the lookup returns pre-update contents; no bypass. The update is visible from the next cycle.
- clear=1:
  - All valid bits go to 0 and all counters to 0 at the next edge.
  - Takes priority over a simultaneous update, which is dropped.
- Reset (asynchronous, active-low):
  - All valid bits and counters go to 0 immediately, even mid-operation.
  - hit, pred_taken and pred_target read 0 while reset is low and after release until the first allocation.
  - Tags and targets need no reset.
- Outputs are pure functions of fetch_pc and state. No X on outputs after reset for any fetch_pc.
- Storage: flops or distributed RAM with an asynchronous read port; no block-RAM read latency is permitted.

Optional Feature:
- Macro: BTP_STATS_EN.
- Defined:
  - Adds outputs stat_lookups[31:0], stat_hits[31:0] and stat_mispredicts[31:0].
  - stat_lookups increments on each cycle with fetch_valid=1.
  - stat_hits increments on each cycle with fetch_valid=1 and hit=1.
  - stat_mispredicts increments on each cycle with upd_valid=1 and upd_mispredict=1.
  - All counters wrap at 2^32, reset to 0 on reset, and are unaffected by clear.
- Undefined: the ports and logic are absent; fetch_valid and upd_mispredict are ignored.

Test Plan (defaults: ENTRIES=16, CNT_W=2):
- Reset, then fetch_pc=0x00000040 → hit=0, pred_taken=0, pred_target=0.
- upd pc=0x40, taken=1, target=0x100; next cycle fetch 0x40 → hit=1, pred_taken=1, pred_target=0x100, counter=2.
- Counter walk on pc=0x40:
  - One not-taken update → counter=1, pred_taken=0, hit=1; a second not-taken → 0, and a third stays 0.
  - Four taken updates → counter saturates at 3, pred_taken=1.
  - Not-taken updates on a missing pc 0x44 → hit stays 0.
- Aliasing and same-cycle ordering:
  - upd pc=0x80, taken, target=0x200 replaces idx 0 → fetch 0x40 misses; fetch 0x80 gives target 0x200.
  - Fetch 0x80000040 never hits an entry written via 0x00000040.
  - Lookup of 0x80 in the same cycle as its first allocation → hit=0.
- clear and upd_valid asserted in the same cycle → next cycle all lookups miss and the update is absent.
- Reset pulsed low mid-run with hits active → hit=0 asynchronously, before the next clk edge.
- With BTP_STATS_EN defined → 10 fetch_valid cycles with 4 hits and 3 mispredict updates give counters 10, 4 and 3.
